// File: rtl/haar_mac_if.sv
// Pixel-pair / coefficient bundle between the DWT control logic and haar_mac.
// The control logic holds the master side; the lifting unit holds the slave side.
interface haar_mac_if #(
   parameter int PW = 8
);
   logic [15:0]   i_pix;
   logic          i_valid;
   logic          i_mode;
   logic [PW-1:0] i_row_column_pointer;
   logic [PW-1:0] i_pixel_pointer;
   logic [15:0]   o_coef;
   logic          o_valid;
   logic          o_mode;
   logic [PW-1:0] o_row_column_pointer;
   logic [PW-1:0] o_pixel_pointer;
   logic [15:0]   o_pair_count;
   logic [15:0]   o_sat_count;
   logic          o_busy;

   modport master (
      output i_pix, i_valid, i_mode, i_row_column_pointer, i_pixel_pointer,
      input  o_coef, o_valid, o_mode, o_row_column_pointer, o_pixel_pointer,
             o_pair_count, o_sat_count, o_busy
   );

   modport slave (
      input  i_pix, i_valid, i_mode, i_row_column_pointer, i_pixel_pointer,
      output o_coef, o_valid, o_mode, o_row_column_pointer, o_pixel_pointer,
             o_pair_count, o_sat_count, o_busy
   );
endinterface

// File: rtl/haar_mac.sv
// haar_mac: three-stage Haar lifting unit returning {L, H} with aligned sideband.
// Define HAAR_MAC_ROUND_EN for round-half-up arithmetic, detail clamp and a live saturation count.
module haar_mac #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256
) (
   input logic       clk,
   input logic       rst,
   haar_mac_if.slave mac
);
   localparam int PW = $clog2(WIDTH);

   // Valid-only flow: a beat is taken whenever i_valid is 1 and there is no ready;
   // o_valid qualifies o_coef and the sideband for exactly the cycle it is high.
   logic              v1, v2, v3;
   logic [7:0]        a1, b1;
   logic              mode1, mode2, mode3;
   logic [PW-1:0]     rc1, rc2, rc3;
   logic [PW-1:0]     pp1, pp2, pp3;
   logic [8:0]        sum2;
   logic signed [8:0] diff2;
   logic [15:0]       coef3;
   logic              prev_mode;
   logic [15:0]       pair_count;
   logic [9:0]        l_full;
   logic signed [9:0] diff_ext;
   logic signed [9:0] h_full;
   logic [7:0]        l_val, h_val;
`ifdef HAAR_MAC_ROUND_EN
   logic              sat;
   logic [15:0]       sat_count;
`endif
   logic              unused_bits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1    <= 1'b0;
         a1    <= '0;
         b1    <= '0;
         mode1 <= 1'b0;
         rc1   <= '0;
         pp1   <= '0;
      end else begin
         v1 <= mac.i_valid;
         if (mac.i_valid) begin
            a1    <= mac.i_pix[15:8];
            b1    <= mac.i_pix[7:0];
            mode1 <= mac.i_mode;
            rc1   <= mac.i_row_column_pointer;
            pp1   <= mac.i_pixel_pointer;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2    <= 1'b0;
         sum2  <= '0;
         diff2 <= '0;
         mode2 <= 1'b0;
         rc2   <= '0;
         pp2   <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            sum2  <= {1'b0, a1} + {1'b0, b1};
            diff2 <= $signed({1'b0, a1}) - $signed({1'b0, b1});
            mode2 <= mode1;
            rc2   <= rc1;
            pp2   <= pp1;
         end
      end
   end

   // Detail is formed in 10 bits so the rounded +1 case (256) is visible to the clamp.
   always_comb begin
      diff_ext = {diff2[8], diff2};
`ifdef HAAR_MAC_ROUND_EN
      l_full = {1'b0, sum2} + 10'd1;
      h_full = ((diff_ext + 10'sd1) >>> 1) + 10'sd128;
      sat    = (h_full > 10'sd255);
      h_val  = sat ? 8'hFF : h_full[7:0];
`else
      l_full = {1'b0, sum2};
      h_full = (diff_ext >>> 1) + 10'sd128;
      h_val  = h_full[7:0];
`endif
      l_val = l_full[8:1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v3         <= 1'b0;
         coef3      <= '0;
         mode3      <= 1'b0;
         rc3        <= '0;
         pp3        <= '0;
         prev_mode  <= 1'b0;
         pair_count <= '0;
      end else begin
         v3 <= v2;
         if (v2) begin
            coef3     <= {l_val, h_val};
            mode3     <= mode2;
            rc3       <= rc2;
            pp3       <= pp2;
            prev_mode <= mode2;
            if (mode2 != prev_mode) begin
               pair_count <= 16'd1;
            end else if (pair_count != 16'hFFFF) begin
               pair_count <= pair_count + 16'd1;
            end
         end
      end
   end

`ifdef HAAR_MAC_ROUND_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_count <= '0;
      end else if (v2 && sat && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

   assign mac.o_sat_count = sat_count;
`else
   assign mac.o_sat_count = '0;
`endif

   assign mac.o_coef               = coef3;
   assign mac.o_valid              = v3;
   assign mac.o_mode               = mode3;
   assign mac.o_row_column_pointer = rc3;
   assign mac.o_pixel_pointer      = pp3;
   assign mac.o_pair_count         = pair_count;
   assign mac.o_busy               = v1 | v2 | v3;

   assign unused_bits = ^{l_full[9], l_full[0], h_full[9:8], (HEIGHT > 0)};
endmodule

// File: tb/tb_haar_mac.sv
// Randomized bench for haar_mac: arithmetic reference model with a per-cycle compare
// process, plus hand-computed literal pins for single beat, extremes and pass change.
module tb_haar_mac;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   typedef struct {
      int          due;
      logic [15:0] coef;
      logic        mode;
      logic [7:0]  rc;
      logic [7:0]  pp;
      logic [15:0] pc;
      logic [15:0] sat;
      bit          has_lit;
      logic [15:0] lit_coef;
      logic [15:0] lit_pc;
      logic [15:0] lit_sat;
   } beat_t;

   beat_t exp_q[$];
   int    mdl_pc, mdl_sat, cur_pc, cur_sat;
   bit    mdl_prev;

   haar_mac_if #(.PW(8)) bus ();

   haar_mac #(.WIDTH(256), .HEIGHT(256)) dut (
      .clk (clk),
      .rst (rst_n),
      .mac (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_clear();
      exp_q.delete();
      mdl_pc   = 0;
      mdl_sat  = 0;
      mdl_prev = 1'b0;
      cur_pc   = 0;
      cur_sat  = 0;
   endtask

   task automatic drive(input bit v, input bit [7:0] a, input bit [7:0] b, input bit m,
                        input bit [7:0] rc, input bit [7:0] pp);
      beat_t e;
      int s, d, l, h;
      @(posedge clk); #1;
      bus.i_valid              = v;
      bus.i_pix                = {a, b};
      bus.i_mode               = m;
      bus.i_row_column_pointer = rc;
      bus.i_pixel_pointer      = pp;
      if (v) begin
         s = int'(a) + int'(b);
         d = int'(a) - int'(b);
`ifdef HAAR_MAC_ROUND_EN
         l = (s + 1) / 2;
         h = (d + 257) / 2;
         if (h > 255) begin
            h = 255;
            if (mdl_sat < 65535) mdl_sat++;
         end
`else
         l = s / 2;
         h = (d + 256) / 2;
`endif
         if (m != mdl_prev) mdl_pc = 1;
         else if (mdl_pc < 65535) mdl_pc++;
         mdl_prev  = m;
         e.due     = cyc + 3;
         e.coef    = {l[7:0], h[7:0]};
         e.mode    = m;
         e.rc      = rc;
         e.pp      = pp;
         e.pc      = mdl_pc[15:0];
         e.sat     = mdl_sat[15:0];
         e.has_lit = 1'b0;
         e.lit_coef = '0;
         e.lit_pc   = '0;
         e.lit_sat  = '0;
         exp_q.push_back(e);
      end
   endtask

   task automatic pin(input logic [15:0] coef, input logic [15:0] pc, input logic [15:0] sat);
      exp_q[exp_q.size()-1].has_lit  = 1'b1;
      exp_q[exp_q.size()-1].lit_coef = coef;
      exp_q[exp_q.size()-1].lit_pc   = pc;
      exp_q[exp_q.size()-1].lit_sat  = sat;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'd0, 8'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      beat_t e;
      bit    busy_exp;
      if (!rst_n) begin
         chk("rst_valid", 32'(bus.o_valid), 32'd0);
         chk("rst_coef", 32'(bus.o_coef), 32'd0);
         chk("rst_side", {bus.o_mode, bus.o_row_column_pointer, bus.o_pixel_pointer}, 32'd0);
         chk("rst_pair_count", 32'(bus.o_pair_count), 32'd0);
         chk("rst_sat_count", 32'(bus.o_sat_count), 32'd0);
         chk("rst_busy", 32'(bus.o_busy), 32'd0);
      end else begin
         busy_exp = 1'b0;
         foreach (exp_q[i])
            if ((exp_q[i].due - 3 < cyc) && (cyc <= exp_q[i].due)) busy_exp = 1'b1;
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("latency", 32'(cyc), 32'(e.due));
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e       = exp_q.pop_front();
            cur_pc  = int'(e.pc);
            cur_sat = int'(e.sat);
            chk("valid", 32'(bus.o_valid), 32'd1);
            chk("coef", 32'(bus.o_coef), 32'(e.coef));
            chk("mode", 32'(bus.o_mode), 32'(e.mode));
            chk("row_column_pointer", 32'(bus.o_row_column_pointer), 32'(e.rc));
            chk("pixel_pointer", 32'(bus.o_pixel_pointer), 32'(e.pp));
            if (e.has_lit) begin
               chk("lit_coef", 32'(bus.o_coef), 32'(e.lit_coef));
               chk("lit_pair_count", 32'(bus.o_pair_count), 32'(e.lit_pc));
               chk("lit_sat_count", 32'(bus.o_sat_count), 32'(e.lit_sat));
            end
         end else begin
            chk("valid_idle", 32'(bus.o_valid), 32'd0);
         end
         chk("pair_count", 32'(bus.o_pair_count), 32'(cur_pc));
         chk("sat_count", 32'(bus.o_sat_count), 32'(cur_sat));
         chk("busy", 32'(bus.o_busy), 32'(busy_exp));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          m;
      bit          v;
      logic [15:0] lo_ext, hi_ext, hi_sat;
`ifdef HAAR_MAC_ROUND_EN
      lo_ext = {8'd128, 8'd1};
      hi_ext = {8'd128, 8'd255};
      hi_sat = 16'd1;
`else
      lo_ext = {8'd127, 8'd0};
      hi_ext = {8'd127, 8'd255};
      hi_sat = 16'd0;
`endif
      model_clear();
      rst_n                    = 1'b0;
      bus.i_valid              = 1'b1;
      bus.i_pix                = 16'($urandom);
      bus.i_mode               = 1'b1;
      bus.i_row_column_pointer = 8'($urandom);
      bus.i_pixel_pointer      = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.i_valid              = 1'($urandom);
         bus.i_pix                = 16'($urandom);
         bus.i_mode               = 1'($urandom);
         bus.i_row_column_pointer = 8'($urandom);
         bus.i_pixel_pointer      = 8'($urandom);
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      rst_n       = 1'b1;
      idle(10);

      drive(1'b1, 8'd200, 8'd100, 1'b0, 8'd5, 8'd8);
      pin({8'd150, 8'd178}, 16'd1, 16'd0);
      idle(3);
      drive(1'b1, 8'd0, 8'd255, 1'b0, 8'd1, 8'd2);
      pin(lo_ext, 16'd2, 16'd0);
      drive(1'b1, 8'd255, 8'd0, 1'b0, 8'd3, 8'd4);
      pin(hi_ext, 16'd3, hi_sat);
      idle(4);

      for (int i = 0; i < 12; i++)
         drive((i % 3) != 2, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom));
      idle(4);

      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'($urandom), 8'($urandom), (i >= 4), 8'(i), 8'(2 * i));
         pin(exp_q[exp_q.size()-1].coef, (i < 4) ? 16'(i + 1) : 16'(i - 3),
             exp_q[exp_q.size()-1].sat);
      end
      idle(4);

      m = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) m = ~m;
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0)
            drive(v, 8'($urandom_range(250, 255)), 8'($urandom_range(0, 3)), m,
                  8'($urandom), 8'($urandom));
         else
            drive(v, 8'($urandom), 8'($urandom), m, 8'($urandom), 8'($urandom));
      end
      idle(4);

      for (int i = 0; i < 3; i++)
         drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom));
      pulse_reset();
      idle(6);
      drive(1'b1, 8'd10, 8'd20, 1'b1, 8'd7, 8'd6);
      drive(1'b1, 8'd255, 8'd0, 1'b1, 8'd7, 8'd8);
      idle(6);

      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
